// File: rtl/bt_pkg.sv
// Shared definitions for the Bluetooth command receiver and its tick generator.
// Holds the FSM state enum, divider/timeout derivations and command width.
// Pure declarations; no logic, so no latency or flow control of its own.
package bt_pkg;

    localparam int CMD_W         = 16;
    localparam int STOP_CODE_DEF = 88;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    // Clocks per oversampling tick, integer floor.
    function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
        return clk_hz / (baud * ovs);
    endfunction

    // Clock cycles of silence before the command is dropped.
    function automatic int calc_timeout(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider: emits a one-clock tick every DIV clocks from reset.
// Latency: first tick DIV clocks after reset release, then every DIV clocks.
// No backpressure; the tick is a pure timing strobe.
module baud_tick_gen #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap;

    // Count 0..DIV-1 and wrap; the wrap cycle is the tick.
    always_comb begin
        wrap  = (cnt_q == CW'(DIV - 1));
        cnt_d = wrap ? '0 : cnt_q + CW'(1);
        tick  = wrap;
    end

    // Divider counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bt_cmd_rx.sv
// 8N1 UART receiver turning app bytes into a 16-bit command with link-loss failsafe.
// Latency: cmd/cmd_valid update 1 clk after the mid-stop-bit tick (~9.5 bits after start edge).
// No backpressure: cmd_valid/frame_err are single-clock pulses, consumer must sample them.
module bt_cmd_rx
    import bt_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVS        = 16,
    parameter int TIMEOUT_MS = 500,
    parameter int STOP_CODE  = STOP_CODE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_valid,
    output logic             frame_err,
    output logic             stop_req,
    output logic             link_alive
);
    localparam int DIV   = calc_div(CLK_HZ, BAUD, OVS);
    localparam int LIMIT = calc_timeout(CLK_HZ, TIMEOUT_MS);
    localparam int TW    = $clog2(LIMIT + 1);

    // Start bit is checked half a bit in; data/stop bits one full bit apart.
    localparam logic [3:0] SC_MID    = 4'(OVS / 2 - 1);
    localparam logic [3:0] SC_LAST   = 4'(OVS - 1);
    localparam logic [7:0] STOP_BYTE = 8'(STOP_CODE);

    logic tick;

    baud_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchroniser; line idles high so both reset to 1.
    logic rx_meta_q;
    logic rs;

    // Synchronise the asynchronous rx line into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rs        <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rs        <= rx_meta_q;
        end
    end

    rx_state_t         state_q, state_d;
    logic [3:0]        sc_q, sc_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              byte_ok;
    logic              byte_bad;

    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              stop_req_q, stop_req_d;
    logic              link_alive_q, link_alive_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic              to_act_q, to_act_d;
    logic              expire;

    // Frame FSM: start qualification, LSB-first data capture, stop check.
    always_comb begin
        state_d  = state_q;
        sc_d     = sc_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        byte_ok  = 1'b0;
        byte_bad = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rs) begin
                    state_d = ST_START;
                    sc_d    = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (sc_q == SC_MID) begin
                        if (rs) begin
                            // Low pulse shorter than half a bit: treat as glitch.
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                            sc_d    = '0;
                            bit_d   = '0;
                        end
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (sc_q == SC_LAST) begin
                        sc_d    = '0;
                        shift_d = {rs, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (sc_q == SC_LAST) begin
                        sc_d = '0;
                        if (rs) begin
                            byte_ok = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            byte_bad = 1'b1;
                            state_d  = ST_WAIT_HIGH;
                        end
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // Break or stuck-low line: wait for idle before hunting again.
                if (rs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Command register, pulses and silence timeout; a new byte beats expiry.
    always_comb begin
        cmd_d        = cmd_q;
        cmd_valid_d  = 1'b0;
        frame_err_d  = byte_bad;
        stop_req_d   = stop_req_q;
        link_alive_d = link_alive_q;
        to_cnt_d     = to_cnt_q;
        to_act_d     = to_act_q;
        expire       = to_act_q && (to_cnt_q == TW'(LIMIT - 1));
        if (byte_ok) begin
            cmd_d        = {{(CMD_W - 8){1'b0}}, shift_q};
            cmd_valid_d  = 1'b1;
            stop_req_d   = (shift_q == STOP_BYTE);
            link_alive_d = 1'b1;
            to_cnt_d     = '0;
            to_act_d     = 1'b1;
        end else if (expire) begin
            // Fire once, then park the counter until the next byte.
            cmd_d        = '0;
            stop_req_d   = 1'b0;
            link_alive_d = 1'b0;
            to_act_d     = 1'b0;
        end else if (to_act_q) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sc_q         <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            cmd_q        <= '0;
            cmd_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            stop_req_q   <= 1'b0;
            link_alive_q <= 1'b0;
            to_cnt_q     <= '0;
            to_act_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sc_q         <= sc_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            frame_err_q  <= frame_err_d;
            stop_req_q   <= stop_req_d;
            link_alive_q <= link_alive_d;
            to_cnt_q     <= to_cnt_d;
            to_act_q     <= to_act_d;
        end
    end

    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign frame_err  = frame_err_q;
    assign stop_req   = stop_req_q;
    assign link_alive = link_alive_q;

endmodule
